bids_n_ctrl: RTL

BIDS_N_CTRL -- requirements
Module: bids_n_ctrl

---
 rtl/bids_n_ctrl.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/bids_n_ctrl.sv
// Sealed-bid auction controller: locked configuration, per-bidder balance
// accounting, bid/retract handling during a round and a one-cycle result phase.
module bids_n_ctrl #(
  parameter int N_BIDDERS = 4,
  parameter int AMT_W     = 16,
  parameter int BAL_W     = 32,
  localparam int IDX_W    = $clog2(N_BIDDERS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [3:0]                 C_op,
  input  logic [BAL_W-1:0]           C_data,
  input  logic [IDX_W-1:0]           C_idx,
  input  logic                       C_start,
  input  logic [N_BIDDERS-1:0]       bid_req,
  input  logic [N_BIDDERS-1:0]       retract,
  input  logic [N_BIDDERS*AMT_W-1:0] bid_amt,
  output logic                       ready,
  output logic [N_BIDDERS-1:0]       ack,
  output logic [2*N_BIDDERS-1:0]     bidder_err,
  output logic [N_BIDDERS*BAL_W-1:0] balance,
  output logic [2:0]                 err,
  output logic                       roundOver,
  output logic [AMT_W-1:0]           maxBid,
  output logic [N_BIDDERS-1:0]       win,
  output logic                       win_valid
);

  typedef enum logic [2:0] {S_UNLOCK, S_LOCK, S_ROUND, S_RESULT, S_LOCKOUT} state_t;

  state_t                 state_q, state_d;
  logic [BAL_W-1:0]       bal_q [N_BIDDERS];
  logic [BAL_W-1:0]       bal_d [N_BIDDERS];
  logic [AMT_W-1:0]       cur_q [N_BIDDERS];
  logic [AMT_W-1:0]       cur_d [N_BIDDERS];
  logic [N_BIDDERS-1:0]   mask_q, mask_d;
  logic [BAL_W-1:0]       timer_q, timer_d, cost_q, cost_d, key_q, key_d, cnt_q, cnt_d;
  logic                   tie_q, tie_d;
  logic                   ready_q, ready_d, rover_q, rover_d, winv_q, winv_d;
  logic [N_BIDDERS-1:0]   ack_q, ack_d, win_q, win_d;
  logic [2*N_BIDDERS-1:0] berr_q, berr_d;
  logic [2:0]             err_q, err_d;
  logic [AMT_W-1:0]       maxbid_q, maxbid_d;

  logic [AMT_W-1:0]       max_v, amt_v;
  logic [BAL_W:0]         need_v;
  logic [N_BIDDERS-1:0]   first_oh;
  logic                   found, multi;

  always_comb begin
    state_d  = state_q;
    bal_d    = bal_q;
    cur_d    = cur_q;
    mask_d   = mask_q;
    timer_d  = timer_q;
    cost_d   = cost_q;
    key_d    = key_q;
    cnt_d    = cnt_q;
    tie_d    = tie_q;
    ready_d  = 1'b1;
    rover_d  = 1'b0;
    ack_d    = '0;
    berr_d   = '0;
    err_d    = err_q;
    win_d    = win_q;
    winv_d   = winv_q;
    maxbid_d = maxbid_q;
    amt_v    = '0;
    need_v   = '0;

    // Zero entries never beat a nonzero bid, so a plain max covers "nonzero only".
    max_v    = '0;
    first_oh = '0;
    found    = 1'b0;
    multi    = 1'b0;
    for (int unsigned i = 0; i < N_BIDDERS; i++)
      if (cur_q[i] > max_v) max_v = cur_q[i];
    for (int unsigned i = 0; i < N_BIDDERS; i++) begin
      if (max_v != '0 && cur_q[i] == max_v) begin
        if (found) multi = 1'b1;
        else       first_oh[i] = 1'b1;
        found = 1'b1;
      end
    end

    if (!(state_q == S_ROUND && C_start))
      for (int unsigned i = 0; i < N_BIDDERS; i++)
        if (bid_req[i] || retract[i]) berr_d[2*i +: 2] = 2'b01;

    case (state_q)
      S_UNLOCK: begin
        if (C_start) err_d = 3'b011;
        else begin
          case (C_op)
            4'd0: ;
            4'd1: err_d = 3'b010;
            4'd2: begin key_d = C_data; state_d = S_LOCK; err_d = 3'b000; end
            4'd3: begin
              if (int'(C_idx) < N_BIDDERS) bal_d[C_idx] = C_data;
              err_d = 3'b000;
            end
            4'd4: begin mask_d  = C_data[N_BIDDERS-1:0]; err_d = 3'b000; end
            4'd5: begin timer_d = C_data;                err_d = 3'b000; end
            4'd6: begin cost_d  = C_data;                err_d = 3'b000; end
            4'd7: begin tie_d   = C_data[0];             err_d = 3'b000; end
            default: err_d = 3'b100;
          endcase
        end
      end
      S_LOCK: begin
        if (C_start) begin
          state_d  = S_ROUND;
          cur_d    = '{default: '0};
          win_d    = '0;
          winv_d   = 1'b0;
          maxbid_d = '0;
        end else begin
          case (C_op)
            4'd0: ;
            4'd1: begin
              if (C_data == key_q) begin state_d = S_UNLOCK; err_d = 3'b000; end
              else begin state_d = S_LOCKOUT; err_d = 3'b001; cnt_d = timer_q; end
            end
            4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7: err_d = 3'b110;
            default: err_d = 3'b100;
          endcase
        end
      end
      S_ROUND: begin
        if (!C_start) state_d = S_RESULT;
        else begin
          for (int unsigned i = 0; i < N_BIDDERS; i++) begin
            amt_v  = bid_amt[i*AMT_W +: AMT_W];
            need_v = (BAL_W+1)'(amt_v) + (BAL_W+1)'(cost_q);
            if (bid_req[i]) begin
              if (!mask_q[i]) berr_d[2*i +: 2] = 2'b11;
              else if ({1'b0, bal_q[i]} >= need_v) begin
                cur_d[i] = amt_v;
                bal_d[i] = bal_q[i] - cost_q;
                ack_d[i] = 1'b1;
              end else begin
                berr_d[2*i +: 2] = 2'b10;
                if (bal_q[i] >= cost_q) bal_d[i] = bal_q[i] - cost_q;
              end
            end
            // Retract is applied after the same-cycle bid so the charge stands.
            if (retract[i]) cur_d[i] = '0;
          end
        end
      end
      S_RESULT: begin
        rover_d  = 1'b1;
        state_d  = S_LOCK;
        maxbid_d = max_v;
        if (max_v == '0) begin
          win_d = '0; winv_d = 1'b0; err_d = 3'b000;
        end else if (multi && !tie_q) begin
          win_d = '0; winv_d = 1'b0; err_d = 3'b101;
        end else begin
          win_d = first_oh; winv_d = 1'b1; err_d = 3'b000;
          for (int unsigned i = 0; i < N_BIDDERS; i++)
            if (first_oh[i])
              bal_d[i] = (bal_q[i] >= BAL_W'(max_v)) ? bal_q[i] - BAL_W'(max_v) : '0;
        end
      end
      S_LOCKOUT: begin
        if (cnt_q == '0) state_d = S_LOCK;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = S_UNLOCK;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_UNLOCK;
      bal_q    <= '{default: '0};
      cur_q    <= '{default: '0};
      mask_q   <= '1;
      timer_q  <= BAL_W'(15);
      cost_q   <= BAL_W'(1);
      key_q    <= '0;
      cnt_q    <= '0;
      tie_q    <= 1'b0;
      ready_q  <= 1'b0;
      rover_q  <= 1'b0;
      ack_q    <= '0;
      berr_q   <= '0;
      err_q    <= '0;
      win_q    <= '0;
      winv_q   <= 1'b0;
      maxbid_q <= '0;
    end else begin
      state_q  <= state_d;
      bal_q    <= bal_d;
      cur_q    <= cur_d;
      mask_q   <= mask_d;
      timer_q  <= timer_d;
      cost_q   <= cost_d;
      key_q    <= key_d;
      cnt_q    <= cnt_d;
      tie_q    <= tie_d;
      ready_q  <= ready_d;
      rover_q  <= rover_d;
      ack_q    <= ack_d;
      berr_q   <= berr_d;
      err_q    <= err_d;
      win_q    <= win_d;
      winv_q   <= winv_d;
      maxbid_q <= maxbid_d;
    end
  end

  always_comb begin
    balance = '0;
    for (int unsigned i = 0; i < N_BIDDERS; i++) balance[i*BAL_W +: BAL_W] = bal_q[i];
  end

  assign ready      = ready_q;
  assign ack        = ack_q;
  assign bidder_err = berr_q;
  assign err        = err_q;
  assign roundOver  = rover_q;
  assign maxBid     = maxbid_q;
  assign win        = win_q;
  assign win_valid  = winv_q;

endmodule
